// File: rtl/simple_ram_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : simple_ram_if
// Brief    : Access bus for simple_ram: shared address, write enable/data,
//            read enable and registered read data.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface simple_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_WIDTH  = 16
);
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] address;
  logic [MEM_WIDTH-1:0]  WrData;
  logic [MEM_WIDTH-1:0]  RdData;

  modport master (
    output WrEn,
    output RdEn,
    output address,
    output WrData,
    input  RdData
  );

  modport slave (
    input  WrEn,
    input  RdEn,
    input  address,
    input  WrData,
    output RdData
  );
endinterface
`default_nettype wire

// File: rtl/simple_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : simple_ram
// Brief    : Single-port synchronous RAM, separate write/read enables,
//            registered read port, asynchronous active-low clear of all
//            storage. Out-of-range addresses never touch storage and read 0.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module simple_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 8,
  parameter int MEM_WIDTH  = 16
) (
  input  wire         CLK,
  input  wire         RST,
  simple_ram_if.slave bus
);

  // Index width into the storage array; address bits above this are only
  // used to detect out-of-range accesses (no aliasing).
  localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] C_DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 in_range;
  logic [IDX_WIDTH-1:0] idx;

  // Decode address: range check against the implemented depth.
  always_comb begin
    in_range = ({1'b0, bus.address} < C_DEPTH);
    idx      = bus.address[IDX_WIDTH-1:0];
  end

  // Storage: cleared on reset, written only for in-range addresses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.WrEn && in_range) begin
      mem[idx] <= bus.WrData;
    end
  end

  // Read register: loads only when reading without a competing write;
  // out-of-range reads return zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data <= '0;
    end else if (bus.RdEn && !bus.WrEn) begin
      rd_data <= in_range ? mem[idx] : '0;
    end
  end

  assign bus.RdData = rd_data;

endmodule
`default_nettype wire

// File: tb/tb_simple_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_simple_ram
// Brief    : Self-checking bench for simple_ram: directed scenarios plus
//            randomized traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_simple_ram;
  localparam int ADDR_WIDTH = 4;
  localparam int MEM_DEPTH  = 8;
  localparam int MEM_WIDTH  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [MEM_WIDTH-1:0] ref_mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] ref_rd;

  simple_ram_if #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_WIDTH(MEM_WIDTH)) bus ();

  simple_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_WIDTH (MEM_WIDTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  // Compare one observed value with its expectation and count it.
  task automatic check_value(input string tag, input logic [MEM_WIDTH-1:0] obs,
                             input logic [MEM_WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endtask

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, check RdData shortly after it.
  task automatic cycle(input string tag, input logic we, input logic re,
                       input int a, input logic [MEM_WIDTH-1:0] d);
    @(negedge CLK);
    bus.WrEn    = we;
    bus.RdEn    = re;
    bus.address = a[ADDR_WIDTH-1:0];
    bus.WrData  = d;
    @(posedge CLK);
    if (we) begin
      if (a < MEM_DEPTH) ref_mem[a] = d;
    end else if (re) begin
      ref_rd = (a < MEM_DEPTH) ? ref_mem[a] : '0;
    end
    #1;
    check_value(tag, bus.RdData, ref_rd);
  endtask

  initial begin
    logic [MEM_WIDTH-1:0] held;
    bus.WrEn = 1'b0; bus.RdEn = 1'b0; bus.address = '0; bus.WrData = '0;
    model_clear();
    #12;
    check_value("reset_rd", bus.RdData, '0);
    @(negedge CLK);
    RST = 1'b1;

    // Write then read
    cycle("wr3",      1'b1, 1'b0, 3, 16'hAC31);
    cycle("rd3",      1'b0, 1'b1, 3, 16'h0000);
    check_value("rd3_const", bus.RdData, 16'hAC31);

    // Independent locations
    cycle("wr6",      1'b1, 1'b0, 6, 16'h0025);
    cycle("rd6",      1'b0, 1'b1, 6, 16'h0000);
    check_value("rd6_const", bus.RdData, 16'h0025);
    cycle("wr1",      1'b1, 1'b0, 1, 16'h1031);
    cycle("rd1",      1'b0, 1'b1, 1, 16'h0000);
    check_value("rd1_const", bus.RdData, 16'h1031);
    cycle("rd6_again",1'b0, 1'b1, 6, 16'h0000);
    cycle("rd3_again",1'b0, 1'b1, 3, 16'h0000);
    cycle("rd1_again",1'b0, 1'b1, 1, 16'h0000);

    // Simultaneous enables: write wins, RdData holds
    cycle("both_en",  1'b1, 1'b1, 5, 16'h5A5A);
    check_value("both_hold", bus.RdData, 16'h1031);
    cycle("rd5",      1'b0, 1'b1, 5, 16'h0000);
    check_value("rd5_const", bus.RdData, 16'h5A5A);

    // Hold: both enables low, address and data wiggle
    held = bus.RdData;
    for (int i = 0; i < 5; i++) begin
      cycle("hold", 1'b0, 1'b0, int'($urandom_range(0, 15)), 16'($urandom));
      check_value("hold_const", bus.RdData, held);
    end
    for (int a = 0; a < MEM_DEPTH; a++) cycle("hold_mem", 1'b0, 1'b1, a, 16'h0);

    // Asynchronous reset mid-run, away from a clock edge
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_value("async_rst", bus.RdData, '0);
    model_clear();
    @(negedge CLK);
    RST = 1'b1;
    for (int a = 0; a < MEM_DEPTH; a++) cycle("post_rst", 1'b0, 1'b1, a, 16'h0);

    // Out-of-range: writes ignored, reads return 0, no aliasing
    cycle("wr3b",     1'b1, 1'b0, 3, 16'h1234);
    cycle("rd3b",     1'b0, 1'b1, 3, 16'h0);
    cycle("wr12",     1'b1, 1'b0, 12, 16'hFFFF);
    cycle("rd12",     1'b0, 1'b1, 12, 16'h0);
    check_value("rd12_const", bus.RdData, 16'h0000);
    cycle("rd4",      1'b0, 1'b1, 4, 16'h0);
    check_value("rd4_const", bus.RdData, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
            16'($urandom));
    end
    for (int a = 0; a < MEM_DEPTH; a++) cycle("final_mem", 1'b0, 1'b1, a, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simple_ram.md
# simple_ram

Single-port synchronous RAM with separate write and read enables and a registered read port. It serves as a small general-purpose storage block: one address bus is shared by reads and writes, and write data and read data use separate buses. Memory contents and the read register are cleared by an asynchronous active-low reset.

## Interface
Parameters:
- ADDR_WIDTH, default 4: width of the address bus.
- MEM_DEPTH, default 8: number of words implemented. Valid addresses are 0 to MEM_DEPTH-1.
- MEM_WIDTH, default 16: word width in bits.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- RST, input, 1: reset, asynchronous and active-low.
- WrEn, input, 1: write enable.
- RdEn, input, 1: read enable.
- address, input, ADDR_WIDTH: word address, shared by reads and writes.
- WrData, input, MEM_WIDTH: data to write.
- RdData, output, MEM_WIDTH: registered read data.

## Operation
- Storage is MEM_DEPTH words of MEM_WIDTH bits each.
- Reset (RST=0), applied at any time regardless of clock:
  - every memory word is cleared to 0;
  - RdData is cleared to 0;
  - clocked activity is blocked while RST is low.
- Write: on a rising CLK edge with RST=1 and WrEn=1, mem[address] <= WrData.
- Read: on a rising CLK edge with RST=1, RdEn=1 and WrEn=0, RdData <= mem[address].
- Both WrEn=1 and RdEn=1 in the same cycle:
  - the write has priority and is performed;
  - no read occurs and RdData holds its value.
- Neither enable asserted: memory and RdData hold.
- Out-of-range address (address >= MEM_DEPTH, e.g. 8 to 15 with the defaults):
  - writes are ignored and no stored word changes;
  - reads load RdData with 0.
- No aliasing or wrap-around of out-of-range addresses.

## Timing
- Write latency: the data is stored at the first rising edge with WrEn=1. A read of that address enabled in any later cycle returns the new data.
- Read latency: 1 cycle. RdData reflects mem[address] sampled at the rising edge where RdEn=1, and is valid after that edge until the next read or reset.
- RdData is never combinational from address; changes to address between edges have no effect on RdData.
- No read-during-write forwarding is needed, because a read is suppressed whenever WrEn=1.
- Reset assertion takes effect immediately (asynchronous).
- Reset release is observed at the next rising edge; that edge may already perform a write or read.
- No handshake and no ready/valid signalling: every enabled operation completes in one cycle.

## Test plan
- Reset check: assert RST=0 mid-run, then release. Read addresses 0 to 7 -> every read returns 16'h0000; RdData reads 0 immediately on assertion.
- Write then read:
  - write 16'hAC31 to address 3 for one cycle;
  - next cycle drop WrEn and set RdEn=1;
  - after that edge RdData = 16'hAC31.
- Independent locations:
  - write 16'h0025 to address 6, then 16'h1031 to address 1, each followed by a read of the same address -> 16'h0025 and 16'h1031 respectively;
  - then read address 6 -> 16'h0025, and read address 3 -> 16'hAC31 (no cross-address corruption).
- Simultaneous enables:
  - with RdData = 16'h1031, drive WrEn=1 and RdEn=1 with address 5 and WrData 16'h5A5A;
  - RdData stays 16'h1031;
  - a later read of address 5 -> 16'h5A5A.
- Hold behaviour: with both enables low, toggle address and WrData for several cycles -> RdData unchanged and memory unchanged.
- Out-of-range:
  - write 16'hFFFF to address 12, then read address 12 -> RdData = 16'h0000;
  - read address 4 (address 12 mod 8) -> value unchanged, i.e. 0 after reset.
